// File: rtl/ddr_burst_writer.sv
// Stream-to-Avalon-MM burst writer: buffers a word stream in a FIFO and writes it to
// consecutive memory addresses as fixed-length bursts, with a shorter final burst if needed.
module ddr_burst_writer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [23:0]           total_words,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_W-1:0]     snk_data,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic [6:0]            avm_burstcount,
    input  logic                  avm_waitrequest
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;

    typedef enum logic [1:0] {StIdle, StWaitData, StBurst, StFinish} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [23:0]         remaining_q, remaining_d;
    logic [23:0]         total_q, total_d;
    logic [23:0]         accepted_q, accepted_d;
    logic [6:0]          len_q, len_d;
    logic [6:0]          beats_q, beats_d;
    logic [6:0]          next_len;
    logic [ADDR_W-1:0]   incr;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                push, pop, full;

    assign busy      = (state_q == StWaitData) || (state_q == StBurst);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign snk_ready = busy && !full && (accepted_q < total_q);
    assign push      = snk_valid && snk_ready;
    assign avm_write = (state_q == StBurst);
    assign pop       = avm_write && !avm_waitrequest;

    assign next_len = (remaining_q < 24'(BURST_LEN)) ? remaining_q[6:0] : 7'(BURST_LEN);
    assign incr     = ADDR_W'(32'(len_q) * BYTES);

    // Outputs are gated by state so reset forces them to zero without waiting for a clock.
    assign avm_address    = avm_write ? addr_q : '0;
    assign avm_burstcount = avm_write ? len_q : '0;
    assign avm_writedata  = avm_write ? mem[rd_ptr_q] : '0;
    assign avm_byteenable = avm_write ? '1 : '0;

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= snk_data;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            total_q     <= '0;
            accepted_q  <= '0;
            len_q       <= '0;
            beats_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            total_q     <= total_d;
            accepted_q  <= accepted_d;
            len_q       <= len_d;
            beats_q     <= beats_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        total_d     = total_q;
        accepted_d  = accepted_q + 24'(push);
        len_d       = len_q;
        beats_d     = beats_q;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = total_words;
                    total_d     = total_words;
                    accepted_d  = '0;
                    state_d     = (total_words == 24'd0) ? StFinish : StWaitData;
                end
            end
            StWaitData: begin
                if (32'(count_q) >= 32'(next_len)) begin
                    len_d   = next_len;
                    beats_d = next_len;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (pop) begin
                    remaining_d = remaining_q - 24'd1;
                    beats_d     = beats_q - 7'd1;
                    // Leaving through WaitData guarantees an idle cycle between bursts.
                    if (beats_q == 7'd1) begin
                        addr_d  = addr_q + incr;
                        state_d = (remaining_q == 24'd1) ? StFinish : StWaitData;
                    end
                end
            end
            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ddr_burst_writer.sv
// Directed self-checking bench for ddr_burst_writer with default parameters
// (32-bit data and address, 8-beat bursts, 32-word FIFO).
module tb_ddr_burst_writer;

    localparam logic [31:0] DBASE = 32'hC0DE_0000;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [23:0] total_words = '0;
    logic        busy, done;
    logic [31:0] snk_data = '0;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [6:0]  avm_burstcount;
    logic        avm_waitrequest = 1'b0;

    int total = 0;
    int bad = 0;

    int bursts, popped, pushed, done_cnt, done_cyc, data_err, stab_err, gap_err, be_err;
    int ready_extra, full_seen, full_ready_err, pp_seen, pp_ready_err, timeout;
    logic busy_at_done, busy_seen;
    logic [31:0] b_addr [8];
    logic [6:0]  b_len [8];

    ddr_burst_writer dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .total_words     (total_words),
        .busy            (busy),
        .done            (done),
        .snk_data        (snk_data),
        .snk_valid       (snk_valid),
        .snk_ready       (snk_ready),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_burstcount  (avm_burstcount),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk_clk = ~clk_clk;

    // 0: never stall, 1: 50% random stalls, 2: stall for the first 60 cycles.
    function automatic logic wreq(input int wmode, input int cyc);
        if (wmode == 1) return ($urandom_range(0, 1) == 1);
        if (wmode == 2) return (cyc < 60);
        return 1'b0;
    endfunction

    // Runs one transfer with a continuous stream, recording what the master did.
    task automatic run_transfer(input logic [31:0] base, input logic [23:0] n,
                                input int wmode, input int restart_at);
        logic pw, pwr, push, pop, prev_pp, finished;
        logic [31:0] pa, pd;
        logic [6:0] pb, cur_len;
        int bib, fill, cyc;
        bursts = 0; popped = 0; pushed = 0; done_cnt = 0; done_cyc = -1; data_err = 0;
        stab_err = 0; gap_err = 0; be_err = 0; ready_extra = 0; full_seen = 0;
        full_ready_err = 0; pp_seen = 0; pp_ready_err = 0; timeout = 0;
        busy_at_done = 1'b0; busy_seen = 1'b0;
        pw = 0; pwr = 0; pa = '0; pd = '0; pb = '0; cur_len = '0; bib = 0; cyc = 0;
        prev_pp = 0; finished = 0;
        base_addr = base; total_words = n; snk_valid = 1'b1; snk_data = DBASE;
        avm_waitrequest = wreq(wmode, 0); start = 1'b1;
        @(posedge clk_clk); #1;
        start = 1'b0;
        while (!finished && cyc < 3000) begin
            fill = pushed - popped;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++; done_cyc = cyc; busy_at_done = busy; finished = 1'b1;
            end
            if (snk_ready && pushed >= int'(n)) ready_extra++;
            if (fill == 32) begin
                full_seen = 1;
                if (snk_ready) full_ready_err++;
            end
            if (prev_pp && fill < 32 && pushed < int'(n) && busy && !snk_ready) pp_ready_err++;
            push = snk_valid && snk_ready;
            pop = avm_write && !avm_waitrequest;
            if (push && pop) pp_seen++;
            if (avm_write) begin
                if (avm_byteenable !== 4'hF) be_err++;
                if (!pw) begin
                    if (bursts < 8) begin
                        b_addr[bursts] = avm_address; b_len[bursts] = avm_burstcount;
                    end
                    bursts++; bib = 0; cur_len = avm_burstcount;
                end else begin
                    if (pwr && (avm_address !== pa || avm_burstcount !== pb
                                || avm_writedata !== pd)) stab_err++;
                    if (bib >= int'(cur_len)) gap_err++;
                end
                if (pop) begin
                    if (avm_writedata !== DBASE + 32'(popped)) data_err++;
                    popped++; bib++;
                end
            end
            pw = avm_write; pwr = avm_waitrequest; pa = avm_address;
            pb = avm_burstcount; pd = avm_writedata; prev_pp = push && pop;
            @(posedge clk_clk); #1;
            if (push) pushed++;
            snk_data = DBASE + 32'(pushed);
            cyc++;
            avm_waitrequest = wreq(wmode, cyc);
            start = (cyc == restart_at);
            if (start) begin
                base_addr = 32'h9000; total_words = 24'd3;
            end
        end
        start = 1'b0; snk_valid = 1'b0; avm_waitrequest = 1'b0;
        if (!finished) timeout = 1;
        @(posedge clk_clk); #1;
    endtask

    task automatic test_reset;
        reset_reset_n = 1'b0; start = 1'b1; snk_valid = 1'b1; total_words = 24'd5;
        repeat (2) @(posedge clk_clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst.busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst.done got=%b want=0", done); end
        total++; if (snk_ready !== 1'b0) begin bad++; $display("FAIL rst.ready got=%b want=0", snk_ready); end
        total++; if (avm_write !== 1'b0) begin bad++; $display("FAIL rst.write got=%b want=0", avm_write); end
        total++; if (avm_address !== 32'h0) begin bad++; $display("FAIL rst.addr got=%h want=0", avm_address); end
        total++; if (avm_burstcount !== 7'h0) begin bad++; $display("FAIL rst.bc got=%h want=0", avm_burstcount); end
        total++; if (avm_writedata !== 32'h0) begin bad++; $display("FAIL rst.wdata got=%h want=0", avm_writedata); end
        total++; if (avm_byteenable !== 4'h0) begin bad++; $display("FAIL rst.be got=%h want=0", avm_byteenable); end
        start = 1'b0; snk_valid = 1'b0; total_words = '0;
        #3 reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;
    endtask

    task automatic test_two_bursts;
        run_transfer(32'h1000, 24'd16, 0, -1);
        total++; if (timeout != 0) begin bad++; $display("FAIL two.timeout got=%0d want=0", timeout); end
        total++; if (bursts != 2) begin bad++; $display("FAIL two.bursts got=%0d want=2", bursts); end
        total++; if (b_addr[0] !== 32'h1000) begin bad++; $display("FAIL two.addr0 got=%h want=1000", b_addr[0]); end
        total++; if (b_addr[1] !== 32'h1020) begin bad++; $display("FAIL two.addr1 got=%h want=1020", b_addr[1]); end
        total++; if (b_len[0] !== 7'd8) begin bad++; $display("FAIL two.len0 got=%0d want=8", b_len[0]); end
        total++; if (b_len[1] !== 7'd8) begin bad++; $display("FAIL two.len1 got=%0d want=8", b_len[1]); end
        total++; if (popped != 16) begin bad++; $display("FAIL two.beats got=%0d want=16", popped); end
        total++; if (data_err != 0) begin bad++; $display("FAIL two.data got=%0d want=0", data_err); end
        total++; if (gap_err != 0) begin bad++; $display("FAIL two.gap got=%0d want=0", gap_err); end
        total++; if (be_err != 0) begin bad++; $display("FAIL two.be got=%0d want=0", be_err); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL two.done got=%0d want=1", done_cnt); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL two.busy_done got=%b want=0", busy_at_done); end
    endtask

    task automatic test_short_tail;
        run_transfer(32'h4000, 24'd11, 0, -1);
        total++; if (bursts != 2) begin bad++; $display("FAIL tail.bursts got=%0d want=2", bursts); end
        total++; if (b_addr[0] !== 32'h4000) begin bad++; $display("FAIL tail.addr0 got=%h want=4000", b_addr[0]); end
        total++; if (b_addr[1] !== 32'h4020) begin bad++; $display("FAIL tail.addr1 got=%h want=4020", b_addr[1]); end
        total++; if (b_len[0] !== 7'd8) begin bad++; $display("FAIL tail.len0 got=%0d want=8", b_len[0]); end
        total++; if (b_len[1] !== 7'd3) begin bad++; $display("FAIL tail.len1 got=%0d want=3", b_len[1]); end
        total++; if (pushed != 11) begin bad++; $display("FAIL tail.pushed got=%0d want=11", pushed); end
        total++; if (ready_extra != 0) begin bad++; $display("FAIL tail.ready_after got=%0d want=0", ready_extra); end
        total++; if (data_err != 0) begin bad++; $display("FAIL tail.data got=%0d want=0", data_err); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL tail.done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_wait_stalls;
        run_transfer(32'h0800, 24'd24, 1, -1);
        total++; if (timeout != 0) begin bad++; $display("FAIL stall.timeout got=%0d want=0", timeout); end
        total++; if (stab_err != 0) begin bad++; $display("FAIL stall.stable got=%0d want=0", stab_err); end
        total++; if (popped != 24) begin bad++; $display("FAIL stall.beats got=%0d want=24", popped); end
        total++; if (data_err != 0) begin bad++; $display("FAIL stall.data got=%0d want=0", data_err); end
        total++; if (bursts != 3) begin bad++; $display("FAIL stall.bursts got=%0d want=3", bursts); end
        total++; if (b_addr[2] !== 32'h0840) begin bad++; $display("FAIL stall.addr2 got=%h want=840", b_addr[2]); end
    endtask

    task automatic test_fifo_full;
        run_transfer(32'h2000, 24'd40, 2, -1);
        total++; if (full_seen != 1) begin bad++; $display("FAIL full.reached got=%0d want=1", full_seen); end
        total++; if (full_ready_err != 0) begin bad++; $display("FAIL full.ready got=%0d want=0", full_ready_err); end
        total++; if (pp_seen == 0) begin bad++; $display("FAIL full.pushpop got=%0d want>0", pp_seen); end
        total++; if (pp_ready_err != 0) begin bad++; $display("FAIL full.count got=%0d want=0", pp_ready_err); end
        total++; if (stab_err != 0) begin bad++; $display("FAIL full.stable got=%0d want=0", stab_err); end
        total++; if (popped != 40) begin bad++; $display("FAIL full.beats got=%0d want=40", popped); end
        total++; if (data_err != 0) begin bad++; $display("FAIL full.data got=%0d want=0", data_err); end
        total++; if (b_len[4] !== 7'd8) begin bad++; $display("FAIL full.len4 got=%0d want=8", b_len[4]); end
    endtask

    task automatic test_zero_words;
        run_transfer(32'h5000, 24'd0, 0, -1);
        // done is the cycle right after the start cycle, i.e. the first sample of the run.
        total++; if (done_cyc != 0) begin bad++; $display("FAIL zero.latency got=%0d want=0", done_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero.done got=%0d want=1", done_cnt); end
        total++; if (bursts != 0) begin bad++; $display("FAIL zero.bursts got=%0d want=0", bursts); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL zero.busy got=%b want=0", busy_seen); end
    endtask

    task automatic test_start_ignored;
        run_transfer(32'h2000, 24'd16, 0, 5);
        total++; if (bursts != 2) begin bad++; $display("FAIL ign.bursts got=%0d want=2", bursts); end
        total++; if (b_addr[1] !== 32'h2020) begin bad++; $display("FAIL ign.addr1 got=%h want=2020", b_addr[1]); end
        total++; if (popped != 16) begin bad++; $display("FAIL ign.beats got=%0d want=16", popped); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ign.done got=%0d want=1", done_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign.idle got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_burst;
        int w;
        w = 0;
        base_addr = 32'h3000; total_words = 24'd16; snk_valid = 1'b1; snk_data = DBASE;
        avm_waitrequest = 1'b0; start = 1'b1;
        @(posedge clk_clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (avm_write) w++;
            if (w == 4) break;
            @(posedge clk_clk); #1;
        end
        total++; if (w != 4) begin bad++; $display("FAIL mid.beat4 got=%0d want=4", w); end
        reset_reset_n = 1'b0;
        #1;
        total++; if (avm_write !== 1'b0) begin bad++; $display("FAIL mid.write got=%b want=0", avm_write); end
        total++; if (avm_address !== 32'h0) begin bad++; $display("FAIL mid.addr got=%h want=0", avm_address); end
        total++; if (avm_burstcount !== 7'h0) begin bad++; $display("FAIL mid.bc got=%h want=0", avm_burstcount); end
        total++; if (avm_writedata !== 32'h0) begin bad++; $display("FAIL mid.wdata got=%h want=0", avm_writedata); end
        total++; if (avm_byteenable !== 4'h0) begin bad++; $display("FAIL mid.be got=%h want=0", avm_byteenable); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid.busy got=%b want=0", busy); end
        total++; if (snk_ready !== 1'b0) begin bad++; $display("FAIL mid.ready got=%b want=0", snk_ready); end
        snk_valid = 1'b0;
        #20 reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;
        // Fresh transfer after the abort, also crossing the top of the address space.
        run_transfer(32'hFFFF_FFF0, 24'd16, 0, -1);
        total++; if (bursts != 2) begin bad++; $display("FAIL mid.bursts got=%0d want=2", bursts); end
        total++; if (b_addr[0] !== 32'hFFFF_FFF0) begin bad++; $display("FAIL mid.addr0 got=%h want=fffffff0", b_addr[0]); end
        total++; if (b_addr[1] !== 32'h0000_0010) begin bad++; $display("FAIL mid.wrap got=%h want=10", b_addr[1]); end
        total++; if (data_err != 0) begin bad++; $display("FAIL mid.data got=%0d want=0", data_err); end
        total++; if (popped != 16) begin bad++; $display("FAIL mid.beats got=%0d want=16", popped); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL mid.done got=%0d want=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_short_tail();
        test_wait_stalls();
        test_fifo_full();
        test_zero_words();
        test_start_ignored();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
